wb_queue: RTL

//  Writeback stage directly upstream of RegFile. Collects results from the ALU and load/memory paths.

---
 rtl/wb_queue_if.sv | 28 ++
 rtl/wb_queue.sv | 72 +++++++
 2 files changed

// File: rtl/wb_queue_if.sv
// wb_queue_if: result producers, RegFile write port and optional bypass between execute/memory and RegFile
// Ports (slave = queue side):
//   alu_valid/alu_reg/alu_value -> alu_ready      ALU result offer
//   mem_valid/mem_reg/mem_value -> mem_ready      load result offer (priority over ALU)
//   stall                                         freezes the RegFile write port
//   RegWrite/writeReg/writeValue                  RegFile write port
//   count/full/empty                              occupancy
//   srcA/srcB/ReadA/ReadB -> fwdA/fwdB            operand bypass, only with WB_BYPASS_EN
interface wb_queue_if #(parameter int W = 8, parameter int D = 4, parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic alu_valid, alu_ready, mem_valid, mem_ready, stall, RegWrite, full, empty;
  logic [D-1:0] alu_reg, mem_reg, writeReg;
  logic [W-1:0] alu_value, mem_value, writeValue;
  logic [CW-1:0] count;
`ifdef WB_BYPASS_EN
  logic [D-1:0] srcA, srcB;
  logic [W-1:0] ReadA, ReadB, fwdA, fwdB;
  modport slave(input alu_valid, alu_reg, alu_value, mem_valid, mem_reg, mem_value, stall, srcA, srcB, ReadA, ReadB,
                output alu_ready, mem_ready, RegWrite, writeReg, writeValue, count, full, empty, fwdA, fwdB);
  modport master(output alu_valid, alu_reg, alu_value, mem_valid, mem_reg, mem_value, stall, srcA, srcB, ReadA, ReadB,
                 input alu_ready, mem_ready, RegWrite, writeReg, writeValue, count, full, empty, fwdA, fwdB);
`else
  modport slave(input alu_valid, alu_reg, alu_value, mem_valid, mem_reg, mem_value, stall,
                output alu_ready, mem_ready, RegWrite, writeReg, writeValue, count, full, empty);
  modport master(output alu_valid, alu_reg, alu_value, mem_valid, mem_reg, mem_value, stall,
                 input alu_ready, mem_ready, RegWrite, writeReg, writeValue, count, full, empty);
`endif
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO merging ALU and load results onto the RegFile write port
// Ports: CLK clock; Reset synchronous active-high; bus (wb_queue_if.slave) carries the producer
// handshakes, stall, the RegFile write port, occupancy flags and, with macro WB_BYPASS_EN defined,
// the operand bypass (fwdA/fwdB = youngest pending value for srcA/srcB, else ReadA/ReadB).
module wb_queue #(parameter int W = 8, parameter int D = 4, parameter int DEPTH = 4) (
  input logic CLK,
  input logic Reset,
  wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [D-1:0] reg_q [DEPTH];
  logic [W-1:0] val_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full, empty, push_mem, push_alu, push, pop;
  logic [D-1:0] in_reg;
  logic [W-1:0] in_val;
  // Acceptance ignores a same-cycle pop: a full queue never passes an entry through.
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    push_mem = bus.mem_valid & !full & !Reset;
    push_alu = bus.alu_valid & !bus.mem_valid & !full & !Reset;
    push = push_mem | push_alu;
    pop = !empty & !bus.stall & !Reset;
    in_reg = bus.mem_valid ? bus.mem_reg : bus.alu_reg;
    in_val = bus.mem_valid ? bus.mem_value : bus.alu_value;
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  assign bus.mem_ready = !full & !Reset;
  assign bus.alu_ready = !full & !bus.mem_valid & !Reset;
  assign bus.RegWrite = pop;
  assign bus.writeReg = (empty | Reset) ? '0 : reg_q[rd_q];
  assign bus.writeValue = (empty | Reset) ? '0 : val_q[rd_q];
  assign bus.count = cnt_q;
  assign bus.full = full;
  assign bus.empty = empty;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      reg_q[wr_q] <= in_reg;
      val_q[wr_q] <= in_val;
    end
  end
`ifdef WB_BYPASS_EN
  logic [W-1:0] fwd_a, fwd_b;
  // Walk oldest to youngest so the last match wins; the head still counts while it is being written.
  always_comb begin
    fwd_a = bus.ReadA;
    fwd_b = bus.ReadB;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q && reg_q[rd_q + PW'(i)] == bus.srcA) fwd_a = val_q[rd_q + PW'(i)];
      if (CW'(i) < cnt_q && reg_q[rd_q + PW'(i)] == bus.srcB) fwd_b = val_q[rd_q + PW'(i)];
    end
  end
  assign bus.fwdA = Reset ? bus.ReadA : fwd_a;
  assign bus.fwdB = Reset ? bus.ReadB : fwd_b;
`endif
endmodule
